// File: rtl/general_mux_pipe_if.sv
// Handshake bundle for general_mux_pipe: upstream select/data offer and downstream result.
// The slave modport is the selector's view; master is the driver/monitor view.
interface general_mux_pipe_if #(
   parameter int NUM_INPUTS = 4,
   parameter int WIDTH      = 32,
   parameter int SEL_W      = $clog2(NUM_INPUTS)
);
   logic [NUM_INPUTS*WIDTH-1:0] input_bus;
   logic [SEL_W-1:0]            select;
   logic                        in_valid;
   logic                        in_ready;
   logic [WIDTH-1:0]            output_val;
   logic [SEL_W-1:0]            out_sel;
   logic                        out_valid;
   logic                        out_ready;
   logic                        sel_err;

   modport slave (
      input  input_bus, select, in_valid, out_ready,
      output in_ready, output_val, out_sel, out_valid, sel_err
   );

   modport master (
      output input_bus, select, in_valid, out_ready,
      input  in_ready, output_val, out_sel, out_valid, sel_err
   );
endinterface

// File: rtl/general_mux_pipe.sv
// N-way registered selector behind a valid/ready handshake, with a main register
// and one skid register so upstream and downstream can stall independently.
module general_mux_pipe #(
   parameter int NUM_INPUTS = 4,
   parameter int WIDTH      = 32,
   parameter int SEL_W      = $clog2(NUM_INPUTS)
) (
   input logic                clk,
   input logic                reset,
   general_mux_pipe_if.slave  bus
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   localparam logic [SEL_W:0] NUM_IN_L = (SEL_W+1)'(NUM_INPUTS);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   main_word_q, main_word_d;
   logic [SEL_W-1:0]   main_sel_q, main_sel_d;
   logic [WIDTH-1:0]   skid_word_q, skid_word_d;
   logic [SEL_W-1:0]   skid_sel_q, skid_sel_d;
   logic               in_ready_q, in_ready_d;
   logic               sel_err_q, sel_err_d;

   logic               accept;
   logic               fire;
   logic               out_valid;
   logic               in_range;
   logic [WIDTH-1:0]   picked_word;

   assign accept = bus.in_valid & in_ready_q;
   assign fire   = out_valid & bus.out_ready;

   // Out-of-range selects fall back to channel 0.
   always_comb begin
      in_range    = ({1'b0, bus.select} < NUM_IN_L);
      picked_word = bus.input_bus[WIDTH-1:0];
      for (int k = 0; k < NUM_INPUTS; k++) begin
         if (bus.select == SEL_W'(k)) begin
            picked_word = bus.input_bus[k*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= EMPTY;
         main_word_q <= '0;
         main_sel_q  <= '0;
         in_ready_q  <= 1'b0;
         sel_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_word_q <= main_word_d;
         main_sel_q  <= main_sel_d;
         in_ready_q  <= in_ready_d;
         sel_err_q   <= sel_err_d;
      end
   end

   always_ff @(posedge clk) begin
      skid_word_q <= skid_word_d;
      skid_sel_q  <= skid_sel_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (accept) state_d = ONE;
         ONE: begin
            if (accept && !fire)      state_d = TWO;
            else if (!accept && fire) state_d = EMPTY;
         end
         TWO:     if (fire) state_d = ONE;
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      main_word_d = main_word_q;
      main_sel_d  = main_sel_q;
      skid_word_d = skid_word_q;
      skid_sel_d  = skid_sel_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               main_word_d = picked_word;
               main_sel_d  = bus.select;
            end
         end
         ONE: begin
            if (accept && fire) begin
               main_word_d = picked_word;
               main_sel_d  = bus.select;
            end else if (accept) begin
               skid_word_d = picked_word;
               skid_sel_d  = bus.select;
            end
         end
         TWO: begin
            if (fire) begin
               main_word_d = skid_word_q;
               main_sel_d  = skid_sel_q;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      out_valid  = (state_q != EMPTY);
      in_ready_d = (state_d != TWO);
      sel_err_d  = sel_err_q | (accept & ~in_range);
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid;
   assign bus.output_val = main_word_q;
   assign bus.out_sel    = main_sel_q;
   assign bus.sel_err    = sel_err_q;

endmodule

// File: doc/general_mux_pipe.md
# general_mux_pipe

Parametrised N-way registered selector for the datapath. It generalises the 2:1 destination/operand select to NUM_INPUTS channels of WIDTH bits, and registers the selected word behind a valid/ready handshake. A 2-entry skid buffer lets upstream and downstream stall independently without losing or duplicating data. It sits between a pipeline stage's candidate sources (register file, ALU result, memory data, immediate) and the next stage register.

## Interface
- NUM_INPUTS, default 4: number of selectable channels; legal range is 2 or more.
- WIDTH, default 32: bits per channel.
- SEL_W, default $clog2(NUM_INPUTS): select width. It must satisfy 2^SEL_W ≥ NUM_INPUTS.

Ports:
- clk  input  1: the single clock; all state changes on the rising edge.
- reset  input  1: synchronous, active-high.
- input_bus  input  NUM_INPUTS*WIDTH: flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
- select  input  SEL_W: channel index, sampled together with input_bus.
- in_valid  input  1: upstream offers input_bus and select this cycle.
- in_ready  output  1: block can accept this cycle; driven directly from a flop.
- output_val  output  WIDTH: selected word at the head of the buffer.
- out_sel  output  SEL_W: select value captured with output_val, as presented (raw, not clamped).
- out_valid  output  1: output_val and out_sel are valid.
- out_ready  input  1: downstream accepts this cycle.
- sel_err  output  1: sticky flag; set when an out-of-range select has been accepted.

## Operation
- Accept = in_valid & in_ready. Fire = out_valid & out_ready.
- On accept, the captured word is input_bus channel[select] when select < NUM_INPUTS. Otherwise the captured word is channel 0 and sel_err is set to 1.
- Storage is a main register (drives the outputs) plus one skid register. Both hold {word, select}.
- Occupancy FSM:
  - EMPTY:
    - accept → ONE, main loaded.
  - ONE:
    - accept & fire → ONE, main reloaded with the new entry.
    - accept & !fire → TWO, skid loaded.
    - !accept & fire → EMPTY.
    - otherwise hold.
  - TWO:
    - no accept is possible.
    - fire → ONE, main ← skid.
    - otherwise hold.
- out_valid = (state ≠ EMPTY).
- in_ready flop next value = (next_state ≠ TWO).
- Order is strictly FIFO. No entry is dropped or duplicated.
- While not fired, output_val and out_sel stay stable whatever the inputs do.
- sel_err clears only on reset.
- in_valid while in_ready = 0 has no effect. Upstream must hold its data until accepted, but the block does not check this.

## Timing
- Reset (synchronous): state=EMPTY, out_valid=0, output_val=0, out_sel=0, sel_err=0, in_ready=0. The skid register contents are don't-care.
- in_ready rises the first clock edge after reset deasserts.
- Reset asserted mid-operation discards all buffered entries at that edge; any accept or fire in that cycle is ignored.
- Latency:
  - A word accepted at edge n appears on output_val with out_valid=1 after edge n (visible in cycle n+1).
  - There is no combinational path from input_bus to output_val.
- Throughput: 1 word per cycle while out_ready is held at 1.
- in_ready falls in the cycle after the second entry is captured, i.e. after ONE→TWO. It rises in the cycle after the TWO→ONE fire.
- Simultaneous accept and fire in ONE keeps occupancy unchanged; the new word is visible in the next cycle.
- out_ready is sampled only when out_valid=1. Deasserting out_valid never depends on out_ready combinationally.

## Test plan
- Reset, then select=2, channels {0x11,0x22,0x33,0x44}, one-cycle in_valid, out_ready=1 → output_val=0x33 and out_sel=2 one cycle later; out_valid is high for exactly 1 cycle.
- Stream selects 0,1,2,3,0… for 16 cycles with out_ready=1 → 16 outputs in order with correct values, in_ready constantly 1, no bubbles.
- out_ready=0 while sending 3 words → first two captured, in_ready=0 after the second; output_val holds word 1. Raising out_ready drains words 1 and 2; the third is accepted once in_ready returns and appears in order.
- NUM_INPUTS=3, select=3 accepted → output_val=channel 0 value, out_sel=3, sel_err=1. sel_err stays 1 through later valid selects until reset.
- Assert reset while in TWO → next cycle out_valid=0, output_val=0, in_ready=0; the cycle after, in_ready=1 and no stale word emerges.
- Random in_valid/out_ready for 10k cycles (WIDTH=8, NUM_INPUTS=5) → scoreboard match, no loss or duplication, outputs stable while stalled.
